// File: rtl/blit_scheduler_pkg.sv
// blit_pkg: shared constants and FSM encodings for the blit scheduler
package blit_pkg;
    localparam int COORD_W      = 11;
    localparam int BURST_MAX    = 16;
    localparam int SCREEN_W_DEF = 800;
    localparam int SCREEN_H_DEF = 600;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
endpackage

// File: rtl/blit_scheduler_if.sv
// blit_scheduler_if: scheduler-to-burst-writer bus; master is the scheduler
interface blit_scheduler_if;
    import blit_pkg::*;
    logic [31:0]        framebuffer_baseaddr;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic [7:0]         pixel_data;
    logic               pixel_valid;
    logic               draw;
    logic               pixel_ready;
    logic               wr_bdone;
    modport master (
        output framebuffer_baseaddr, pixel_x, pixel_y, width, height,
        output pixel_data, pixel_valid, draw,
        input  pixel_ready, wr_bdone
    );
    modport slave (
        input  framebuffer_baseaddr, pixel_x, pixel_y, width, height,
        input  pixel_data, pixel_valid, draw,
        output pixel_ready, wr_bdone
    );
endinterface

// File: rtl/blit_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin picker, first request at or after the pointer wins
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);
    localparam logic [NUM_REQ-1:0] ONE = 1;
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;
    // Scan downward so the lowest rotated offset with a request is the one left standing
    always_comb begin
        gnt_idx = '0;
        j = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) gnt_idx = j;
        end
    end
    assign any = |req;
    assign gnt = any ? ONE << gnt_idx : '0;
    // Winner drops to lowest priority once it is taken
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (upd) ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/blit_scheduler.sv
// blit_scheduler: shares one burst pixel writer among NUM_REQ rectangle requesters.
// Define BLIT_SCHEDULER_CLIP_EN to suppress draw for pixels outside SCREEN_W x SCREEN_H.
module blit_scheduler import blit_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         cmd_valid,
    output logic [NUM_REQ-1:0]         cmd_ready,
    input  logic [COORD_W*NUM_REQ-1:0] cmd_x,
    input  logic [COORD_W*NUM_REQ-1:0] cmd_y,
    input  logic [COORD_W*NUM_REQ-1:0] cmd_w,
    input  logic [COORD_W*NUM_REQ-1:0] cmd_h,
    input  logic [8*NUM_REQ-1:0]       src_data,
    input  logic [NUM_REQ-1:0]         src_draw,
    input  logic [NUM_REQ-1:0]         src_valid,
    output logic [NUM_REQ-1:0]         src_ready,
    output logic [NUM_REQ-1:0]         done,
    input  logic [31:0]                fb_base_in,
    blit_scheduler_if.master           wr,
    output logic                       busy,
    output logic [2:0]                 grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = 1;
    if (NUM_REQ < 2 || NUM_REQ > 8 || SCREEN_W < 1 || SCREEN_W > 2048 || SCREEN_H < 1 || SCREEN_H > 2048) begin : g_bad_cfg
        $error("blit_scheduler: parameter out of range");
    end
    logic [2:0]         state;
    logic [IW-1:0]      g;
    logic [IW-1:0]      arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_any;
    logic [COORD_W-1:0] x0, y0, w, h, col, row;
    logic [31:0]        base;
    logic [17:0]        bcnt, need;
    logic [7:0]         row_bursts;
    logic               accept, streaming, beat, last_px, counting;
    assign accept    = (state == S_IDLE) && arb_any;
    assign streaming = state == S_STREAM;
    assign counting  = (state == S_LOAD) || streaming || (state == S_DRAIN);
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk(clk),
        .reset(reset),
        .req(cmd_valid),
        .upd(accept),
        .gnt(arb_gnt),
        .gnt_idx(arb_idx),
        .any(arb_any)
    );
    // Bursts never cross a row, so each row costs ceil((w+1)/BURST_MAX) write responses
    assign row_bursts = 8'((12'(w) + 12'(BURST_MAX)) >> $clog2(BURST_MAX));
    assign need       = 18'(row_bursts) * (18'(h) + 18'd1);
    assign cmd_ready  = accept ? arb_gnt : '0;
    assign src_ready  = (streaming && wr.pixel_ready) ? ONE << g : '0;
    assign done       = (state == S_SETTLE) ? ONE << g : '0;
    assign busy       = state != S_IDLE;
    assign grant_id   = 3'(g);
    assign wr.framebuffer_baseaddr = base;
    assign wr.width       = w;
    assign wr.height      = h;
    assign wr.pixel_x     = x0 + col;
    assign wr.pixel_y     = y0 + row;
    assign wr.pixel_valid = streaming && src_valid[g];
    assign wr.pixel_data  = streaming ? src_data[8*g +: 8] : '0;
`ifdef BLIT_SCHEDULER_CLIP_EN
    logic [COORD_W:0] ux, uy;
    assign ux = {1'b0, x0} + {1'b0, col};
    assign uy = {1'b0, y0} + {1'b0, row};
    assign wr.draw = streaming && src_draw[g] && (ux < 12'(SCREEN_W)) && (uy < 12'(SCREEN_H));
`else
    assign wr.draw = streaming && src_draw[g];
`endif
    assign beat    = wr.pixel_valid && wr.pixel_ready;
    assign last_px = (col == w) && (row == h);
    // Rectangle sequencing: latch on grant, walk pixels raster order, then wait for every burst response
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            g     <= '0;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            base  <= '0;
            col   <= '0;
            row   <= '0;
            bcnt  <= '0;
        end else begin
            if (counting && wr.wr_bdone) bcnt <= bcnt + 18'd1;
            case (state)
                S_IDLE: if (arb_any) begin
                    g     <= arb_idx;
                    x0    <= cmd_x[COORD_W*arb_idx +: COORD_W];
                    y0    <= cmd_y[COORD_W*arb_idx +: COORD_W];
                    w     <= cmd_w[COORD_W*arb_idx +: COORD_W];
                    h     <= cmd_h[COORD_W*arb_idx +: COORD_W];
                    base  <= fb_base_in;
                    col   <= '0;
                    row   <= '0;
                    bcnt  <= '0;
                    state <= S_LOAD;
                end
                S_LOAD:   state <= S_STREAM;
                S_STREAM: if (beat) begin
                    col <= (col == w) ? '0 : col + 1'b1;
                    if (col == w) row <= row + 1'b1;
                    if (last_px) state <= S_DRAIN;
                end
                S_DRAIN:  if (bcnt == need) state <= S_SETTLE;
                S_SETTLE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/blit_scheduler.md
Name: blit_scheduler

Overview:
- Shares the single AXI3 burst pixel writer between NUM_REQ rectangle-draw requesters, for example the sprite engine, the clear engine and the text engine.
- Arbitrates in round-robin order. The grant is held for a whole rectangle.
- Latches the winning rectangle command and drives the writer's width, height and base-address inputs from it.
- Generates per-pixel pixel_x/pixel_y, forwards the winner's pixel stream, and waits for the final write response before re-arbitrating.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SCREEN_W, 800, visible width in pixels (used by the clipping feature only).
- SCREEN_H, 600, visible height in pixels (used by the clipping feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  NUM_REQ  per-requester rectangle command valid.
- cmd_ready  out  NUM_REQ  per-requester command accept.
- cmd_x  in  11*NUM_REQ  origin x, packed, requester i at [11i+:11].
- cmd_y  in  11*NUM_REQ  origin y, packed.
- cmd_w  in  11*NUM_REQ  width minus one, packed.
- cmd_h  in  11*NUM_REQ  height minus one, packed.
- src_data  in  8*NUM_REQ  pixel stream data, packed.
- src_draw  in  NUM_REQ  pixel is opaque (writer asserts byte strobe).
- src_valid  in  NUM_REQ  pixel stream valid.
- src_ready  out  NUM_REQ  pixel stream ready.
- done  out  NUM_REQ  one-cycle pulse when the requester's rectangle is fully written.
- fb_base_in  in  32  current framebuffer base address.
- wr_bdone  in  1  tap of writer bvalid&bready.
- framebuffer_baseaddr  out  32  to writer.
- pixel_x  out  11  to writer.
- pixel_y  out  11  to writer.
- width  out  11  to writer.
- height  out  11  to writer.
- pixel_data  out  8  to writer.
- pixel_valid  out  1  to writer.
- draw  out  1  to writer.
- pixel_ready  in  1  from writer.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  3  index of the current or last granted requester.

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0, except the round-robin pointer, which resets to requester 0 having the highest priority.
- State machine: IDLE, LOAD, STREAM, DRAIN, SETTLE.
- IDLE:
  - If any cmd_valid is set, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Assert cmd_ready[g] combinationally for that cycle only.
  - Latch x0, y0, w, h and fb_base_in.
  - Set grant_id = g, set col = row = 0, and go to LOAD.
  - The pointer becomes g+1 (mod NUM_REQ).
- LOAD: one cycle, with width, height and framebuffer_baseaddr already stable; then go to STREAM.
  - These three outputs stay constant from LOAD until the return to IDLE.
- STREAM, datapath:
  - pixel_valid = src_valid[g]; pixel_data = src_data[g]; draw = src_draw[g]; src_ready[g] = pixel_ready. All are combinational.
  - Non-granted src_ready are 0.
- STREAM, coordinates:
  - pixel_x = x0+col and pixel_y = y0+row. Both are 11-bit sums that wrap modulo 2048.
- STREAM, counting on each pixel_valid & pixel_ready beat:
  - If col == w: col = 0, row++.
  - Otherwise: col++.
  - On the beat where col == w and row == h (the last pixel), go to DRAIN.
  - The total beat count is (w+1)*(h+1).
- DRAIN:
  - pixel_valid = 0 and all src_ready = 0.
  - Count wr_bdone pulses since LOAD. Exit when the count equals the number of bursts issued: per row, ceil((w+1)/16), times (h+1) rows. Pulses arriving during STREAM count toward this.
  - Then go to SETTLE.
- SETTLE:
  - One cycle, covering the writer's return to idle.
  - Pulse done[g] and return to IDLE.
- Boundary cases:
  - w = h = 0 gives a single pixel and one burst.
  - A requester that drops cmd_valid after acceptance is ignored.
  - cmd_valid on the granted requester during STREAM is not accepted until IDLE.
  - If all requesters are valid simultaneously, the pointer order gives strict rotation, with no requester granted twice in a row.
  - A src_valid gap stalls the counters only.
  - Reset mid-rectangle returns to IDLE immediately. The writer is reset by the same signal.
- Counter widths:
  - Burst counter is 18 bits.
  - col and row are 11 bits.

Optional Feature:
- Macro: BLIT_SCHEDULER_CLIP_EN.
- With the macro defined: draw is forced to 0 for any beat where x0+col (12-bit, unwrapped) >= SCREEN_W or y0+row >= SCREEN_H. The beat is still consumed and counted, so the writer's burst length is unaffected.
- Without the macro: draw = src_draw[g] unconditionally. SCREEN_W and SCREEN_H are unused.

Decomposition:
- Shared package blit_pkg:
  - State enum.
  - COORD_W = 11, BURST_MAX = 16.
  - Default SCREEN_W/SCREEN_H.
- One sub-module: rr_arbiter (NUM_REQ request vector, pointer, grant one-hot plus index, update strobe).

Test Plan:
- Single requester 0, x=10, y=20, w=3, h=1 → 8 beats.
  - pixel_x sequence is 10..13 then 10..13; pixel_y is 20 then 21.
  - DRAIN waits for 2 wr_bdone pulses, then done[0] pulses once.
- w=39, h=0 → 3 bursts are expected.
  - done is withheld until the 3rd wr_bdone.
  - width output = 39 throughout STREAM and DRAIN.
- All 4 requesters continuously valid with 1x1 rectangles → grant_id sequence 0,1,2,3,0.
  - cmd_ready is a single-cycle pulse per grant.
- src_valid toggling every other cycle, 2x2 rectangle → coordinates advance only on handshakes. Non-granted src_ready stay 0.
- Reset asserted at the 3rd beat of a 4x4 rectangle.
  - Next cycle: busy = 0, pixel_valid = 0.
  - The next command starts at col = 0, row = 0.
- Clip build, x=798, w=3, all src_draw = 1.
  - draw is 1,1,0,0.
  - 4 beats are consumed and done pulses.
